// File: rtl/sync_debouncer.sv
// Per-channel synchronizer + debouncer with registered edge pulses and
// sticky write-one-to-clear event flags.
module sync_debouncer #(
    parameter int unsigned      WIDTH           = 1,
    parameter int unsigned      SYNC_DEPTH      = 2,
    parameter int unsigned      DEBOUNCE_CYCLES = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] rising_edge,
    output logic [WIDTH-1:0] falling_edge,
    output logic [WIDTH-1:0] event_flags,
    input  logic [WIDTH-1:0] event_clear,
    output logic             any_event
);

    localparam int unsigned CW =
        (DEBOUNCE_CYCLES >= 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    generate
        if (WIDTH < 1 || SYNC_DEPTH < 2 || DEBOUNCE_CYCLES < 1) begin : g_bad_param
            $error("sync_debouncer: illegal parameters WIDTH=%0d SYNC_DEPTH=%0d DEBOUNCE_CYCLES=%0d",
                   WIDTH, SYNC_DEPTH, DEBOUNCE_CYCLES);
        end
    endgenerate

    logic [WIDTH-1:0] r_sync [SYNC_DEPTH];
    logic [CW-1:0]    r_cnt  [WIDTH];
    logic [CW-1:0]    w_cnt_nxt [WIDTH];
    logic [WIDTH-1:0] w_synced;
    logic [WIDTH-1:0] w_flip;
    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] r_rise;
    logic [WIDTH-1:0] r_fall;
    logic [WIDTH-1:0] r_flags;

    assign w_synced = r_sync[SYNC_DEPTH-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned s = 0; s < SYNC_DEPTH; s++) begin
                r_sync[s] <= RESET_VALUE;
            end
        end else begin
            r_sync[0] <= in;
            for (int unsigned s = 1; s < SYNC_DEPTH; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
        end
    end

    // Counter saturates at CNT_LAST; the flip itself resets it, so it never wraps.
    always_comb begin
        w_flip = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            w_cnt_nxt[i] = '0;
            if (w_synced[i] != r_out[i]) begin
                if (r_cnt[i] == CNT_LAST) begin
                    w_flip[i] = 1'b1;
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out   <= RESET_VALUE;
            r_rise  <= '0;
            r_fall  <= '0;
            r_flags <= '0;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_out   <= r_out ^ w_flip;
            r_rise  <= w_flip & w_synced;
            r_fall  <= w_flip & ~w_synced;
            // Set from a pending pulse overrides a same-cycle clear.
            r_flags <= (r_flags & ~event_clear) | r_rise | r_fall;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
        end
    end

    assign out          = r_out;
    assign rising_edge  = r_rise;
    assign falling_edge = r_fall;
    assign event_flags  = r_flags;
    assign any_event    = |r_flags;

endmodule

// File: tb/tb_sync_debouncer.sv
// Bench for sync_debouncer: directed vector table, hand sequences and a
// randomized run against a sliding-window reference model.
module tb_sync_debouncer;

    localparam int unsigned SD_C = 3;
    localparam int unsigned DC_C = 3;
    localparam logic [3:0]  RV_C = 4'b1010;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic [0:0] a_in, a_clr, a_out, a_rise, a_fall, a_flags;
    logic       a_any;
    logic [0:0] b_in, b_clr, b_out, b_rise, b_fall, b_flags;
    logic       b_any;
    logic [3:0] c_in, c_clr, c_out, c_rise, c_fall, c_flags;
    logic       c_any;

    sync_debouncer #(.WIDTH(1), .SYNC_DEPTH(2), .DEBOUNCE_CYCLES(4), .RESET_VALUE(1'b0)) u_a (
        .clk(clk), .rst(rst), .in(a_in), .out(a_out), .rising_edge(a_rise),
        .falling_edge(a_fall), .event_flags(a_flags), .event_clear(a_clr), .any_event(a_any));

    sync_debouncer #(.WIDTH(1), .SYNC_DEPTH(2), .DEBOUNCE_CYCLES(1), .RESET_VALUE(1'b0)) u_b (
        .clk(clk), .rst(rst), .in(b_in), .out(b_out), .rising_edge(b_rise),
        .falling_edge(b_fall), .event_flags(b_flags), .event_clear(b_clr), .any_event(b_any));

    sync_debouncer #(.WIDTH(4), .SYNC_DEPTH(SD_C), .DEBOUNCE_CYCLES(DC_C), .RESET_VALUE(RV_C)) u_c (
        .clk(clk), .rst(rst), .in(c_in), .out(c_out), .rising_edge(c_rise),
        .falling_edge(c_fall), .event_flags(c_flags), .event_clear(c_clr), .any_event(c_any));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic rst, in, clr;
        logic out, rise, fall, flags;
    } vec_t;
    vec_t vecs[$];

    function automatic void add(input int n, input logic r, input logic i, input logic c,
                                input logic o, input logic ri, input logic fa, input logic fl);
        for (int k = 0; k < n; k++) vecs.push_back('{r, i, c, o, ri, fa, fl});
    endfunction

    // Reference: out flips when every one of the last DC_C synced samples differs from it.
    logic [3:0] m_pipe [SD_C];
    logic [3:0] m_hist [DC_C];
    logic [3:0] m_out, m_rise, m_fall, m_flags;

    task automatic model_edge(input logic r, input logic [3:0] i, input logic [3:0] c);
        logic [3:0] synced, diff, nxt;
        if (r) begin
            for (int j = 0; j < int'(SD_C); j++) m_pipe[j] = RV_C;
            for (int j = 0; j < int'(DC_C); j++) m_hist[j] = RV_C;
            m_out = RV_C; m_rise = '0; m_fall = '0; m_flags = '0;
        end else begin
            synced = m_pipe[SD_C-1];
            for (int j = int'(DC_C) - 1; j > 0; j--) m_hist[j] = m_hist[j-1];
            m_hist[0] = synced;
            diff = '1;
            for (int j = 0; j < int'(DC_C); j++) diff = diff & (m_hist[j] ^ m_out);
            nxt     = m_out ^ diff;
            m_flags = (m_flags & ~c) | m_rise | m_fall;
            m_rise  = nxt & ~m_out;
            m_fall  = ~nxt & m_out;
            m_out   = nxt;
            for (int j = int'(SD_C) - 1; j > 0; j--) m_pipe[j] = m_pipe[j-1];
            m_pipe[0] = i;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic applied [0:31];
        logic exp_o, prev_o;

        rst = 1'b1;
        a_in = '0; a_clr = '0; b_in = '0; b_clr = '0; c_in = '0; c_clr = '0;

        // u_a table: latency, short excursion, set-vs-clear, falling edge
        add(1, 1,0,0, 0,0,0,0);
        add(5, 0,1,0, 0,0,0,0);
        add(1, 0,1,0, 1,1,0,0);
        add(2, 0,1,0, 1,0,0,1);
        add(1, 1,0,0, 0,0,0,0);
        add(3, 0,1,0, 0,0,0,0);
        add(5, 0,0,0, 0,0,0,0);
        add(5, 0,1,0, 0,0,0,0);
        add(1, 0,1,0, 1,1,0,0);
        add(1, 0,1,1, 1,0,0,1);
        add(1, 0,1,1, 1,0,0,0);
        add(5, 0,0,0, 1,0,0,0);
        add(1, 0,0,0, 0,0,1,0);
        add(1, 0,0,0, 0,0,0,1);

        foreach (vecs[k]) begin
            rst = vecs[k].rst; a_in = vecs[k].in; a_clr = vecs[k].clr;
            tick();
            check($sformatf("vec%0d out", k),   32'(a_out),   32'(vecs[k].out));
            check($sformatf("vec%0d rise", k),  32'(a_rise),  32'(vecs[k].rise));
            check($sformatf("vec%0d fall", k),  32'(a_fall),  32'(vecs[k].fall));
            check($sformatf("vec%0d flags", k), 32'(a_flags), 32'(vecs[k].flags));
            check($sformatf("vec%0d any", k),   32'(a_any),   32'(vecs[k].flags));
        end
        a_clr = '0;

        // reset at count 2 of 4 discards progress
        a_in = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("midcnt pre out", 32'(a_out), 32'd0);
        end
        rst = 1'b1;
        tick();
        check("midcnt rst out", 32'(a_out), 32'd0);
        check("midcnt rst rise", 32'(a_rise), 32'd0);
        check("midcnt rst flags", 32'(a_flags), 32'd0);
        rst = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            check($sformatf("refill%0d out", k),  32'(a_out),  (k == 6) ? 32'd1 : 32'd0);
            check($sformatf("refill%0d rise", k), 32'(a_rise), (k == 6) ? 32'd1 : 32'd0);
        end
        a_in = '0;

        // u_b: DEBOUNCE_CYCLES=1 tracks input with fixed delay
        rst = 1'b1;
        tick();
        check("b reset out", 32'(b_out), 32'd0);
        rst = 1'b0;
        prev_o = 1'b0;
        for (int k = 0; k < 32; k++) begin
            applied[k] = ((k / 4) % 2 == 0) ? 1'b1 : 1'b0;
            b_in = applied[k];
            tick();
            exp_o = (k >= 2) ? applied[k-2] : 1'b0;
            check($sformatf("b%0d out", k),  32'(b_out),  32'(exp_o));
            check($sformatf("b%0d rise", k), 32'(b_rise), 32'(exp_o & ~prev_o));
            check($sformatf("b%0d fall", k), 32'(b_fall), 32'(~exp_o & prev_o));
            prev_o = exp_o;
        end
        b_in = '0;

        // u_c: reset value then simultaneous opposite edges
        rst = 1'b1; c_in = 4'b0101;
        tick();
        check("c reset out", 32'(c_out), 32'(RV_C));
        check("c reset flags", 32'(c_flags), 32'd0);
        rst = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            check($sformatf("c%0d out", k),  32'(c_out),  (k >= 6) ? 32'h5 : 32'hA);
            check($sformatf("c%0d rise", k), 32'(c_rise), (k == 6) ? 32'h5 : 32'h0);
            check($sformatf("c%0d fall", k), 32'(c_fall), (k == 6) ? 32'hA : 32'h0);
        end
        check("c flags", 32'(c_flags), 32'hF);
        check("c any", 32'(c_any), 32'd1);

        // randomized run on u_c
        rst = 1'b1; c_in = 4'($urandom); c_clr = '0;
        model_edge(1'b1, c_in, c_clr);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 500; k++) begin
            rst   = ($urandom_range(0, 59) == 0);
            c_in  = c_in ^ 4'($urandom & $urandom);
            c_clr = 4'($urandom & $urandom & $urandom);
            model_edge(rst, c_in, c_clr);
            tick();
            check($sformatf("r%0d out", k),   32'(c_out),   32'(m_out));
            check($sformatf("r%0d rise", k),  32'(c_rise),  32'(m_rise));
            check($sformatf("r%0d fall", k),  32'(c_fall),  32'(m_fall));
            check($sformatf("r%0d flags", k), 32'(c_flags), 32'(m_flags));
            check($sformatf("r%0d any", k),   32'(c_any),   32'(|m_flags));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
